bram_stream_reader: RTL and testbench
=====================================

# bram_stream_reader

Read-side streaming engine for the true dual-port block RAM (`bram_dp_true`). It owns one BRAM port and, on a start command, reads `len_i` consecutive words from `base_i`. It presents the words in order on a valid/ready stream. It hides the 1-cycle BRAM read latency behind a 2-entry output buffer, so a continuously-ready sink gets one word per cycle.

## Interface
- `RAM_WIDTH`, 8, data word width; must match the BRAM.
- `RAM_ADDR_BITS`, 10, BRAM address width.
- `LEN_BITS`, `RAM_ADDR_BITS+1`, width of the length field; allows a full-memory read of 2^RAM_ADDR_BITS words.
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `start_i`  in  1  command strobe; sampled only in IDLE.
- `base_i`  in  RAM_ADDR_BITS  first address; captured with `start_i`.
- `len_i`  in  LEN_BITS  word count; captured with `start_i`.
- `busy_o`  out  1  high whenever the state is not IDLE.
- `done_o`  out  1  one-cycle pulse after the last word is accepted.
- `ram_en_o`  out  1  BRAM port enable (read strobe).
- `ram_we_o`  out  1  constant 0.
- `ram_addr_o`  out  RAM_ADDR_BITS  BRAM read address.
- `ram_data_i`  in  RAM_WIDTH  BRAM read data, valid 1 cycle after `ram_en_o`.
- `m_data_o`  out  RAM_WIDTH  stream data (buffer head).
- `m_valid_o`  out  1  stream valid.
- `m_ready_i`  in  1  stream ready.

## Operation
- FSM states:
  - IDLE. Transitions to READ on `start_i` with `len_i` != 0; to DONE on `start_i` with `len_i` == 0.
  - READ. Issues reads. Transitions to DRAIN once the final read has been issued.
  - DRAIN. Waits for the buffer to empty and no read to be in flight, then transitions to DONE.
  - DONE. Transitions unconditionally to IDLE.
- Counters: `rd_left` (LEN_BITS) and `wr_left` (LEN_BITS) are loaded from `len_i`. `addr` (RAM_ADDR_BITS) is loaded from `base_i`.
- Read issue is combinational: `ram_en_o` = (state==READ) && (count + inflight − pop < 2).
  - pop = `m_valid_o` && `m_ready_i`.
  - count is the buffer occupancy (0..2).
  - inflight is a 1-bit flag equal to `ram_en_o` registered.
- Each issue increments `addr` modulo 2^RAM_ADDR_BITS and decrements `rd_left`. The final issue is the one made when `rd_left` == 1.
- Wrap-around: `base_i`=1022, `len_i`=4 reads addresses 1022, 1023, 0, 1.
- Data path: when inflight is high, `ram_data_i` is pushed into the buffer at the clock edge. Push and pop may occur in the same cycle; occupancy is then unchanged.
- `m_valid_o` = (count != 0). `m_data_o` is the buffer head, and is held stable while `m_valid_o` && !`m_ready_i`.
- `wr_left` decrements on each pop. `done_o` is asserted in the DONE state only.
- `start_i` is ignored while busy, and the captured `base_i`/`len_i` are not disturbed.
- `ram_addr_o` = `addr` at all times. It is only meaningful when `ram_en_o` is high.

## Timing
- Reset values: state IDLE; counters, count and inflight all 0.
  - `busy_o`, `done_o`, `ram_en_o`, `ram_we_o`, `m_valid_o` are all 0.
  - `ram_addr_o` and `m_data_o` are 0.
- Reset is asynchronous. Asserting it mid-transfer discards all buffered and in-flight data immediately, with no `done_o`.
- Start sampled at edge N:
  - `busy_o` is high from cycle N+1.
  - First `ram_en_o` is in cycle N+1.
  - First `m_valid_o` is in cycle N+3.
- With `m_ready_i` held high, throughput is 1 word/cycle. The last word is accepted in cycle N+2+len, `done_o` is high in cycle N+3+len, and the block is back in IDLE in cycle N+4+len.
- Zero length: `done_o` is high in cycle N+1 and there is no `ram_en_o`.
- Back-pressure: the buffer never overflows. At most 2 words are held or in flight while `m_ready_i` is low.

## Structure
- Package `bram_pkg` holds:
  - the FSM enum `rd_state_t` {IDLE, READ, DRAIN, DONE};
  - default width constants shared with `bram_dp_true`.
- Sub-module `stream_buf2`: a 2-entry register FIFO with push/pop/count, reusable elsewhere.
- The top level holds the FSM, counters and issue logic.

## Test plan
- Bench structure:
  - Preload `bram_dp_true` via port A with data = 5·(addr+1).
  - Connect `bram_stream_reader` to port B.
  - Check `ram_we_o` == 0 throughout.
- Full-rate read: base 0, len 10, ready always 1 -> `m_data_o` 5,10,…,50 on 10 consecutive cycles, `done_o` one cycle after the last word.
- Back-pressure: base 3, len 6, ready toggling 1/0 each cycle plus a 5-cycle low hold -> 20,25,30,35,40,45 in order, no loss or duplicates, data stable while stalled.
- Wrap: base 1022, len 4 -> addresses 1022,1023,0,1 seen on `ram_addr_o`; matching data streamed.
- Zero length and ignored start: len 0 -> `done_o` at N+1 with no `ram_en_o`. A second `start_i` during a len-8 read -> no effect, exactly 8 words.
- Reset mid-read: assert `rst_i` after 3 of 8 words -> all outputs 0 immediately. A new start afterwards (base 0, len 2) -> 5,10 and `done_o`.

Source files
------------

// File: rtl/bram_pkg.sv
// bram_pkg: shared FSM state type and default BRAM widths for the block-RAM slice
package bram_pkg;
  localparam int RAM_WIDTH_D = 8;
  localparam int RAM_ADDR_BITS_D = 10;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} rd_state_t;
endpackage

// File: rtl/bram_stream_reader_if.sv
// bram_stream_reader_if: valid/ready word stream; master drives data/valid, slave drives ready
interface bram_stream_reader_if #(parameter int W = 8);
  logic [W-1:0] data;
  logic valid;
  logic ready;
  modport master (output data, valid, input ready);
  modport slave (input data, valid, output ready);
endinterface

// File: rtl/bram_dp_true.sv
// bram_dp_true: true dual-port RAM, read-first, 1-cycle read latency; ports a_*/b_* each en/we/addr/din/dout
module bram_dp_true #(
  parameter int RAM_WIDTH = 8,
  parameter int RAM_ADDR_BITS = 10
) (
  input  logic clk_i,
  input  logic a_en_i,
  input  logic a_we_i,
  input  logic [RAM_ADDR_BITS-1:0] a_addr_i,
  input  logic [RAM_WIDTH-1:0] a_din_i,
  output logic [RAM_WIDTH-1:0] a_dout_o,
  input  logic b_en_i,
  input  logic b_we_i,
  input  logic [RAM_ADDR_BITS-1:0] b_addr_i,
  input  logic [RAM_WIDTH-1:0] b_din_i,
  output logic [RAM_WIDTH-1:0] b_dout_o
);
  logic [RAM_WIDTH-1:0] mem [2**RAM_ADDR_BITS];
  always_ff @(posedge clk_i) begin
    if (a_en_i) begin
      if (a_we_i) mem[a_addr_i] <= a_din_i;
      a_dout_o <= mem[a_addr_i];
    end
    if (b_en_i) begin
      if (b_we_i) mem[b_addr_i] <= b_din_i;
      b_dout_o <= mem[b_addr_i];
    end
  end
endmodule

// File: rtl/stream_buf2.sv
// stream_buf2: 2-entry register FIFO; push_i/din_i in, pop_i/dout_o (head) out, count_o occupancy 0..2
module stream_buf2 #(parameter int W = 8) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic [W-1:0] din_i,
  input  logic pop_i,
  output logic [W-1:0] dout_o,
  output logic [1:0] count_o
);
  logic [W-1:0] tail;
  logic do_pop, do_push;
  assign do_pop = pop_i && count_o != 2'd0;
  assign do_push = push_i && (count_o != 2'd2 || do_pop);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      dout_o <= '0;
      tail <= '0;
      count_o <= '0;
    end else begin
      // head only moves on pop or when a push lands in an empty slot, so it holds while stalled
      if (do_pop && count_o == 2'd2) dout_o <= tail;
      else if (do_push && (count_o == 2'd0 || (count_o == 2'd1 && do_pop))) dout_o <= din_i;
      if (do_push && ((count_o == 2'd1 && !do_pop) || (count_o == 2'd2 && do_pop))) tail <= din_i;
      count_o <= count_o + 2'(do_push) - 2'(do_pop);
    end
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: reads len_i words from base_i on one BRAM port and streams them out.
// Ports: clk_i/rst_i; start_i/base_i/len_i command; busy_o/done_o status;
// ram_en_o/ram_we_o/ram_addr_o/ram_data_i BRAM port; m stream master (data/valid/ready).
module bram_stream_reader
  import bram_pkg::*;
#(
  parameter int RAM_WIDTH = RAM_WIDTH_D,
  parameter int RAM_ADDR_BITS = RAM_ADDR_BITS_D,
  parameter int LEN_BITS = RAM_ADDR_BITS + 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic [RAM_ADDR_BITS-1:0] base_i,
  input  logic [LEN_BITS-1:0] len_i,
  output logic busy_o,
  output logic done_o,
  output logic ram_en_o,
  output logic ram_we_o,
  output logic [RAM_ADDR_BITS-1:0] ram_addr_o,
  input  logic [RAM_WIDTH-1:0] ram_data_i,
  bram_stream_reader_if.master m
);
  rd_state_t state;
  logic [LEN_BITS-1:0] rd_left, wr_left;
  logic [RAM_ADDR_BITS-1:0] addr;
  logic [RAM_WIDTH-1:0] head;
  logic [1:0] count;
  logic inflight, pop;
  assign pop = m.valid && m.ready;
  assign m.valid = count != 2'd0;
  assign m.data = head;
  // a read may issue only if the word it returns is guaranteed a free buffer slot
  assign ram_en_o = state == READ && (3'(count) + 3'(inflight) - 3'(pop)) < 3'd2;
  assign ram_we_o = 1'b0;
  assign ram_addr_o = addr;
  stream_buf2 #(.W(RAM_WIDTH)) u_buf (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push_i(inflight),
    .din_i(ram_data_i),
    .pop_i(pop),
    .dout_o(head),
    .count_o(count)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      rd_left <= '0;
      wr_left <= '0;
      addr <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= ram_en_o;
      done_o <= 1'b0;
      if (pop) wr_left <= wr_left - 1'b1;
      case (state)
        IDLE: if (start_i) begin
          addr <= base_i;
          rd_left <= len_i;
          wr_left <= len_i;
          busy_o <= 1'b1;
          state <= len_i != '0 ? READ : DONE;
          done_o <= len_i == '0;
        end
        READ: if (ram_en_o) begin
          addr <= addr + 1'b1;
          rd_left <= rd_left - 1'b1;
          if (rd_left == LEN_BITS'(1)) state <= DRAIN;
        end
        DRAIN: if (!inflight && count == {1'b0, pop} && wr_left == LEN_BITS'(pop)) begin
          state <= DONE;
          done_o <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: streams from a preloaded BRAM and checks words, addresses and timing against a queue model
module tb_bram_stream_reader;
  localparam int W = 8;
  localparam int AB = 10;
  localparam int LB = AB + 1;
  localparam int DEPTH = 1 << AB;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic start_i = 1'b0;
  logic [AB-1:0] base_i = '0;
  logic [LB-1:0] len_i = '0;
  logic busy_o, done_o, ram_en_o, ram_we_o;
  logic [AB-1:0] ram_addr_o;
  logic [W-1:0] ram_data_i, a_dout;
  logic a_en = 1'b0, a_we = 1'b0;
  logic [AB-1:0] a_addr = '0;
  logic [W-1:0] a_din = '0;
  int n_vec = 0, n_err = 0, n_acc = 0, en_cnt = 0;
  bit mon_en = 1'b0, prev_stall = 1'b0;
  logic [W-1:0] prev_d;
  logic [W-1:0] exp_q[$];
  int exp_addr[$];
  bram_stream_reader_if #(.W(W)) s ();
  bram_dp_true #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) u_ram (
    .clk_i(clk_i), .a_en_i(a_en), .a_we_i(a_we), .a_addr_i(a_addr), .a_din_i(a_din), .a_dout_o(a_dout),
    .b_en_i(ram_en_o), .b_we_i(ram_we_o), .b_addr_i(ram_addr_o), .b_din_i('0), .b_dout_o(ram_data_i)
  );
  bram_stream_reader #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_i(base_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .ram_en_o(ram_en_o), .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o), .ram_data_i(ram_data_i), .m(s.master)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [W-1:0] word_at(input int a);
    return W'(5 * (a + 1));
  endfunction
  always @(negedge clk_i) if (mon_en && !rst_i) begin
    chk("we", ram_we_o, 0);
    if (ram_en_o) begin
      en_cnt++;
      if (exp_addr.size() == 0) chk("extra_rd", 1, 0);
      else chk("addr", ram_addr_o, exp_addr.pop_front());
    end
    if (prev_stall) begin
      chk("hold_v", s.valid, 1);
      chk("hold_d", s.data, prev_d);
    end
    if (s.valid && s.ready) begin
      n_acc++;
      if (exp_q.size() == 0) chk("extra_wd", 1, 0);
      else chk("data", s.data, exp_q.pop_front());
    end
    prev_stall = s.valid && !s.ready;
    prev_d = s.data;
  end
  // mode 0: ready held, 1: random ready, 2: toggle with a 5-cycle low hold; dbl: second start mid-run
  task automatic run(input int base, input int len, input int mode, input bit dbl);
    int done_c = 0, first_v = 0, first_en = 0, lim;
    bit fin = 0;
    lim = 20 * len + 40;
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back((base + i) % DEPTH);
      exp_q.push_back(word_at((base + i) % DEPTH));
    end
    en_cnt = 0;
    @(posedge clk_i); #1;
    start_i = 1'b1; base_i = AB'(base); len_i = LB'(len); s.ready = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int c = 1; c <= lim && !fin; c++) begin
      s.ready = mode == 0 ? 1'b1 : mode == 1 ? ($urandom_range(3) != 0) : ((c >= 6 && c <= 10) ? 1'b0 : c[0]);
      if (dbl && c == 3) begin start_i = 1'b1; base_i = 500; len_i = 3; end
      if (dbl && c == 4) start_i = 1'b0;
      @(negedge clk_i);
      if (c == 1) chk("busy1", busy_o, 1);
      if (ram_en_o && first_en == 0) first_en = c;
      if (s.valid && first_v == 0) first_v = c;
      if (done_c != 0 && c == done_c + 1) begin
        chk("idle_after", busy_o, 0);
        chk("done_pulse", done_o, 0);
        fin = 1;
      end
      if (done_o && done_c == 0) done_c = c;
      @(posedge clk_i); #1;
    end
    if (!fin) chk("timeout", 0, 1);
    chk("en_cnt", en_cnt, len);
    chk("left_wd", exp_q.size(), 0);
    chk("left_rd", exp_addr.size(), 0);
    if (len == 0) chk("done_z", done_c, 1);
    else if (mode == 0) begin
      chk("first_en", first_en, 1);
      chk("first_v", first_v, 3);
      chk("done_t", done_c, len + 3);
    end
    exp_q.delete(); exp_addr.delete();
  endtask
  initial begin
    s.ready = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_en", ram_en_o, 0);
    chk("rst_valid", s.valid, 0);
    chk("rst_addr", ram_addr_o, 0);
    chk("rst_data", s.data, 0);
    rst_i = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      @(posedge clk_i); #1;
      a_en = 1'b1; a_we = 1'b1; a_addr = AB'(a); a_din = word_at(a);
    end
    @(posedge clk_i); #1;
    a_en = 1'b0; a_we = 1'b0;
    mon_en = 1'b1;
    run(0, 10, 0, 0);
    run(3, 6, 2, 0);
    run(1022, 4, 0, 0);
    run(7, 0, 0, 0);
    run(100, 8, 0, 1);
    for (int k = 0; k < 12; k++) run($urandom_range(DEPTH - 1), $urandom_range(1, 40), 1, 0);
    run(1000, 30, 2, 0);
    for (int i = 0; i < 8; i++) begin
      exp_addr.push_back(i);
      exp_q.push_back(word_at(i));
    end
    n_acc = 0;
    @(posedge clk_i); #1;
    start_i = 1'b1; base_i = 0; len_i = 8; s.ready = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int c = 0; c < 40 && n_acc < 3; c++) @(posedge clk_i);
    chk("acc3", n_acc, 3);
    mon_en = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk("mid_busy", busy_o, 0);
    chk("mid_done", done_o, 0);
    chk("mid_en", ram_en_o, 0);
    chk("mid_valid", s.valid, 0);
    chk("mid_addr", ram_addr_o, 0);
    chk("mid_data", s.data, 0);
    exp_q.delete(); exp_addr.delete();
    prev_stall = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    mon_en = 1'b1;
    run(0, 2, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
